// File: rtl/sprite_probe_pkg.sv
// sprite_probe_pkg: screen geometry, colour constants and the draw/probe state encoding.
package sprite_probe_pkg;
  localparam int SCREEN_W   = 128;
  localparam int SCREEN_H   = 120;
  localparam int ADDR_W     = 14;
  localparam int SPRITE_DIM = 4;
  localparam int COLOUR_W   = 3;
  localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/sprite_probe_if.sv
// sprite_probe_if: framebuffer read port; master issues reads, slave returns data a cycle later.
interface sprite_probe_if;
  import sprite_probe_pkg::*;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [COLOUR_W-1:0] rd_data;
  modport master (output rd_en, rd_addr, input rd_data);
  modport slave (input rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/probe_addr_gen.sv
// probe_addr_gen: walks the 16 tile offsets, bounds-checks each pixel and issues framebuffer reads.
module probe_addr_gen
  import sprite_probe_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [6:0]        x_in,
  input  logic [6:0]        y_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              offscreen,
  output logic              last
);
  logic [6:0] x_q, y_q;
  logic [3:0] off, off_n;
  logic [7:0] px, py;
  logic active, in_bounds;
  logic [ADDR_W-1:0] addr_n;
  // The first slot is computed straight from the inputs so it is on the bus the cycle after load.
  always_comb begin
    off_n = load ? 4'd0 : off + 4'd1;
    px = {1'b0, load ? x_in : x_q} + {6'b0, off_n[1:0]};
    py = {1'b0, load ? y_in : y_q} + {6'b0, off_n[3:2]};
    in_bounds = 32'(px) < SCREEN_W && 32'(py) < SCREEN_H;
    addr_n = ADDR_W'(32'(py) * SCREEN_W + 32'(px));
  end
  assign last = active && off == 4'd15;
  always_ff @(posedge clk)
    if (!resetn) begin
      active <= 1'b0;
      off <= '0;
      x_q <= '0;
      y_q <= '0;
      rd_en <= 1'b0;
      offscreen <= 1'b0;
      rd_addr <= '0;
    end else if (load || (active && !last)) begin
      active <= 1'b1;
      off <= off_n;
      rd_en <= in_bounds;
      offscreen <= !in_bounds;
      if (in_bounds) rd_addr <= addr_n;
      if (load) begin
        x_q <= x_in;
        y_q <= y_in;
      end
    end else begin
      active <= 1'b0;
      rd_en <= 1'b0;
      offscreen <= 1'b0;
    end
endmodule

// File: rtl/sprite_probe.sv
// sprite_probe: reads back a 4x4 framebuffer tile and counts non-background or off-screen pixels.
module sprite_probe
  import sprite_probe_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [6:0]     x_in,
  input  logic [6:0]     y_in,
  sprite_probe_if.master fb,
  output logic           busy,
  output logic           done,
  output logic           hit,
  output logic [4:0]     hit_count
);
  state_t state, state_n;
  logic accept, last, offscreen, v_q, off_q, pix_hit;
  probe_addr_gen u_gen (
    .clk       (clk),
    .resetn    (resetn),
    .load      (accept),
    .x_in      (x_in),
    .y_in      (y_in),
    .rd_en     (fb.rd_en),
    .rd_addr   (fb.rd_addr),
    .offscreen (offscreen),
    .last      (last)
  );
  always_comb begin
    accept = state == IDLE && start;
    state_n = state == IDLE  ? (start ? ISSUE : IDLE) :
              state == ISSUE ? (last ? DRAIN : ISSUE) :
              state == DRAIN ? DONE : IDLE;
    pix_hit = v_q && (off_q || fb.rd_data != BG_COLOUR);
  end
  // v_q/off_q delay each slot by one cycle so it lines up with its returned pixel.
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hit <= 1'b0;
      hit_count <= '0;
      v_q <= 1'b0;
      off_q <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n == ISSUE || state_n == DRAIN;
      done <= state_n == DONE;
      v_q <= fb.rd_en || offscreen;
      off_q <= offscreen;
      if (accept) begin
        hit <= 1'b0;
        hit_count <= '0;
      end else if (pix_hit) begin
        hit <= 1'b1;
        hit_count <= hit_count + 5'd1;
      end
    end
endmodule

// File: tb/tb_sprite_probe.sv
// tb_sprite_probe: directed probes against a framebuffer model with hand-computed expectations.
module tb_sprite_probe;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [6:0] x_in = '0, y_in = '0;
  logic busy, done, hit;
  logic [4:0] hit_count;
  logic [2:0] ram [0:16383];
  int tests = 0, fails = 0;
  int done_cyc, n_rd, extra_done;
  logic en_log [0:40];
  logic [13:0] addr_log [0:40];
  logic busy_log [0:40];
  logic hit_at;
  logic [4:0] cnt_at;

  sprite_probe_if fb ();

  sprite_probe dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .fb        (fb),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  initial fb.rd_data = 3'b000;
  always @(posedge clk) if (fb.rd_en) fb.rd_data <= ram[fb.rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a probe, logs bus activity per cycle; pa/pb re-pulse start in those cycles.
  task automatic scan(input logic [6:0] x, input logic [6:0] y, input int pa, input int pb);
    @(negedge clk);
    start = 1'b1; x_in = x; y_in = y;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0; n_rd = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge clk);
      en_log[c] = fb.rd_en;
      addr_log[c] = fb.rd_addr;
      busy_log[c] = busy;
      if (fb.rd_en) n_rd++;
      if (done) begin
        done_cyc = c;
        hit_at = hit;
        cnt_at = hit_count;
      end
      start = (c == pa || c == pb);
      if (start) x_in = 7'd0;
    end
    if (start) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 3'b000;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_count", hit_count, 0);
    chk("rst_rd_en", fb.rd_en, 0);
    chk("rst_rd_addr", fb.rd_addr, 0);
    resetn = 1'b1;

    scan(7'd10, 7'd8, 0, 0);
    chk("blank_done_cyc", done_cyc, 18);
    chk("blank_n_rd", n_rd, 16);
    chk("blank_en_c1", en_log[1], 1);
    chk("blank_en_c16", en_log[16], 1);
    chk("blank_en_c17", en_log[17], 0);
    chk("blank_busy_c1", busy_log[1], 1);
    chk("blank_busy_c18", busy_log[18], 0);
    chk("blank_addr_c1", addr_log[1], 1034);
    chk("blank_addr_c16", addr_log[16], 1421);
    chk("blank_hit", hit_at, 0);
    chk("blank_count", cnt_at, 0);

    ram[9*128+12] = 3'b100;
    scan(7'd10, 7'd8, 0, 0);
    chk("one_addr_c1", addr_log[1], 1034);
    chk("one_addr_c2", addr_log[2], 1035);
    chk("one_addr_c3", addr_log[3], 1036);
    chk("one_addr_c4", addr_log[4], 1037);
    chk("one_addr_c7", addr_log[7], 1164);
    chk("one_hit", hit_at, 1);
    chk("one_count", cnt_at, 1);
    @(negedge clk);
    chk("one_hold_count", hit_count, 1);
    chk("one_hold_hit", hit, 1);

    ram[9*128+12] = 3'b000;
    scan(7'd126, 7'd0, 0, 0);
    chk("right_n_rd", n_rd, 8);
    chk("right_en_c1", en_log[1], 1);
    chk("right_en_c3", en_log[3], 0);
    chk("right_en_c4", en_log[4], 0);
    chk("right_count", cnt_at, 8);
    chk("right_hit", hit_at, 1);

    scan(7'd0, 7'd118, 0, 0);
    chk("bottom_n_rd", n_rd, 8);
    chk("bottom_en_c8", en_log[8], 1);
    chk("bottom_en_c9", en_log[9], 0);
    chk("bottom_count", cnt_at, 8);

    ram[9*128+12] = 3'b100;
    scan(7'd10, 7'd8, 5, 18);
    chk("pulse_done_cyc", done_cyc, 18);
    chk("pulse_count", cnt_at, 1);
    extra_done = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk("pulse_extra_done", extra_done, 0);
    chk("pulse_busy_idle", busy, 0);
    chk("pulse_count_hold", hit_count, 1);

    @(negedge clk);
    start = 1'b1; x_in = 7'd126; y_in = 7'd0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_hit", hit, 0);
    chk("mrst_count", hit_count, 0);
    chk("mrst_rd_en", fb.rd_en, 0);
    chk("mrst_rd_addr", fb.rd_addr, 0);
    resetn = 1'b1;
    scan(7'd10, 7'd8, 0, 0);
    chk("after_done_cyc", done_cyc, 18);
    chk("after_count", cnt_at, 1);
    chk("after_hit", hit_at, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
